// File: rtl/frame_capture_buffer.sv
// Double-banked frame capture buffer.
// An incoming byte stream fills the back bank, and the reader sees only the
// front bank. Once the back bank holds a full frame of 2^AW beats, the two
// banks swap, unless the reader has asserted rd_lock. While the reader holds
// the lock, the finished frame waits in HOLD and any new beats are dropped.
//
// Stream handshake: the input side has no backpressure. A beat is present
// exactly in the cycles where in_valid=1. The block either takes the beat or
// drops it, and it never stalls the source.
//
// fsm_state is a debug view of the capture FSM, encoded as
// 0=SYNC, 1=FILL, 2=HOLD.
module frame_capture_buffer #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_sof,
  input  logic          rd_lock,
  input  logic [AW-1:0] rd_addr,
  input  logic          clear_flags,
  output logic [DW-1:0] rd_data,
  output logic          front_bank,
  output logic          frame_ready,
  output logic [7:0]    frame_count,
  output logic          overrun,
  output logic          short_frame,
  output logic [1:0]    fsm_state
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = '1;
  localparam logic [AW-1:0] ONE  = AW'(1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [AW-1:0] wr_ptr;
  logic          back_bank;

  // Two banks of storage. Contents are deliberately left without reset.
  logic [DW-1:0] mem [2][DEPTH];

  assign back_bank = ~front_bank;
  assign fsm_state = state;

  // Decide whether this beat lands in the back bank, and at which address.
  // A start-of-frame beat always restarts the frame at address 0.
  always_comb begin
    wr_en  = 1'b0;
    wr_ptr = wr_addr;
    case (state)
      SYNC: begin
        if (in_valid && in_sof) begin
          wr_en  = 1'b1;
          wr_ptr = '0;
        end
      end
      FILL: begin
        if (in_valid) begin
          wr_en  = 1'b1;
          wr_ptr = in_sof ? '0 : wr_addr;
        end
      end
      default: begin
        wr_en  = 1'b0;
        wr_ptr = wr_addr;
      end
    endcase
  end

  // Back-bank write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[back_bank][wr_ptr] <= in_data;
  end

  // Capture FSM, bank swap, flags and the registered front-bank read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SYNC;
      wr_addr     <= '0;
      front_bank  <= 1'b0;
      frame_ready <= 1'b0;
      frame_count <= 8'd0;
      overrun     <= 1'b0;
      short_frame <= 1'b0;
      rd_data     <= '0;
    end else begin
      frame_ready <= 1'b0;
      // The read samples front_bank before any swap at this edge, so a read
      // issued in the swap cycle still returns the old frame.
      rd_data     <= mem[front_bank][rd_addr];
      // The flag-set assignments further down override this clear.
      if (clear_flags) begin
        overrun     <= 1'b0;
        short_frame <= 1'b0;
      end
      case (state)
        SYNC: begin
          if (in_valid && in_sof) begin
            wr_addr <= ONE;
            state   <= FILL;
          end
        end
        FILL: begin
          if (in_valid) begin
            if (in_sof) begin
              wr_addr <= ONE;
              if (wr_addr != '0) short_frame <= 1'b1;
            end else if (wr_addr == LAST) begin
              wr_addr <= '0;
              if (rd_lock) begin
                state <= HOLD;
              end else begin
                front_bank  <= ~front_bank;
                frame_ready <= 1'b1;
                frame_count <= frame_count + 8'd1;
              end
            end else begin
              wr_addr <= wr_addr + ONE;
            end
          end
        end
        HOLD: begin
          if (in_valid) overrun <= 1'b1;
          if (!rd_lock) begin
            front_bank  <= ~front_bank;
            frame_ready <= 1'b1;
            frame_count <= frame_count + 8'd1;
            wr_addr     <= '0;
            state       <= FILL;
          end
        end
        default: begin
          state   <= SYNC;
          wr_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Testbench for frame_capture_buffer.
// The driver applies one cycle of stimulus at a time. A frame-level reference
// model predicts what the outputs should be after that clock edge, and the
// prediction is queued. A monitor on the falling edge pops each prediction
// and compares it with the DUT outputs.
module tb_frame_capture_buffer;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // clock / reset
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic          rd_lock = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          clear_flags = 1'b0;
  logic [DW-1:0] rd_data;
  logic          front_bank;
  logic          frame_ready;
  logic [7:0]    frame_count;
  logic          overrun;
  logic          short_frame;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  frame_capture_buffer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .rd_lock(rd_lock), .rd_addr(rd_addr),
    .clear_flags(clear_flags), .rd_data(rd_data), .front_bank(front_bank),
    .frame_ready(frame_ready), .frame_count(frame_count), .overrun(overrun),
    .short_frame(short_frame), .fsm_state(fsm_state)
  );

  typedef struct packed {
    logic [DW-1:0] rd;
    logic          rd_known;
    logic          fb;
    logic          rdy;
    logic [7:0]    cnt;
    logic          ovr;
    logic          shrt;
    logic [1:0]    st;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Reference model: frames are assembled as lists of beats. Only a full
  // 32-beat list is ever published to a bank.
  bit            m_synced;
  bit            m_hold;
  bit            m_front;
  bit            m_ready;
  bit            m_ovr;
  bit            m_short;
  logic [7:0]    m_count;
  logic [DW-1:0] m_beats[$];
  logic [DW-1:0] m_bk[2][N];
  bit            m_known[2][N];

  task automatic model_reset();
    m_synced = 0;
    m_hold   = 0;
    m_front  = 0;
    m_ready  = 0;
    m_ovr    = 0;
    m_short  = 0;
    m_count  = 8'd0;
    m_beats.delete();
  endtask

  task automatic publish();
    bit b;
    b = !m_front;
    for (int i = 0; i < N; i++) begin
      m_bk[b][i]    = m_beats[i];
      m_known[b][i] = 1;
    end
    m_front = b;
    m_count = m_count + 8'd1;
    m_ready = 1;
    m_hold  = 0;
    m_beats.delete();
  endtask

  task automatic model_cycle(input bit v, input logic [DW-1:0] d, input bit sof,
                             input bit lock, input logic [AW-1:0] addr,
                             input bit clr, output exp_t e);
    e.rd_known = m_known[m_front][addr];
    e.rd       = m_bk[m_front][addr];
    m_ready    = 0;
    if (clr) begin
      m_ovr   = 0;
      m_short = 0;
    end
    if (m_hold) begin
      if (v) m_ovr = 1;
      if (!lock) publish();
    end else if (v) begin
      if (sof) begin
        if (m_beats.size() > 0) m_short = 1;
        m_beats.delete();
        m_beats.push_back(d);
        m_synced = 1;
      end else if (m_synced) begin
        m_beats.push_back(d);
      end
      if (m_synced && m_beats.size() == N) begin
        if (lock) m_hold = 1;
        else publish();
      end
    end
    e.fb   = m_front;
    e.rdy  = m_ready;
    e.cnt  = m_count;
    e.ovr  = m_ovr;
    e.shrt = m_short;
    e.st   = !m_synced ? ST_SYNC : (m_hold ? ST_HOLD : ST_FILL);
  endtask

  // driver tasks
  task automatic step(input bit v, input logic [DW-1:0] d, input bit sof,
                      input bit lock, input logic [AW-1:0] addr, input bit clr);
    exp_t e;
    in_valid    = v;
    in_data     = d;
    in_sof      = sof;
    rd_lock     = lock;
    rd_addr     = addr;
    clear_flags = clr;
    model_cycle(v, d, sof, lock, addr, clr, e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] addr);
    step(0, '0, 0, 0, addr, 0);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    @(negedge clk);
    #1;
    in_valid    = 0;
    in_sof      = 0;
    rd_lock     = 0;
    clear_flags = 0;
    reset       = 1;
    model_reset();
    #1;
    tests++;
    if (front_bank !== 1'b0 || frame_ready !== 1'b0 || frame_count !== 8'd0 ||
        overrun !== 1'b0 || short_frame !== 1'b0 || rd_data !== '0 ||
        fsm_state !== ST_SYNC) begin
      fails++;
      $display("FAIL async_reset: got fb=%0d rdy=%0d cnt=%0d ovr=%0d sf=%0d rd=%h st=%0d, need all zero",
               front_bank, frame_ready, frame_count, overrun, short_frame, rd_data, fsm_state);
    end
    e = '{rd: '0, rd_known: 1'b1, fb: 1'b0, rdy: 1'b0, cnt: 8'd0, ovr: 1'b0,
          shrt: 1'b0, st: ST_SYNC};
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      exp_q.push_back(e);
    end
    #1;
    reset = 0;
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) idle(AW'(a));
    idle('0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (front_bank !== e.fb || frame_ready !== e.rdy || frame_count !== e.cnt ||
          overrun !== e.ovr || short_frame !== e.shrt || fsm_state !== e.st ||
          (e.rd_known && rd_data !== e.rd)) begin
        fails++;
        $display("FAIL outputs@%0d: got fb=%0d rdy=%0d cnt=%0d ovr=%0d sf=%0d st=%0d rd=%h ; need fb=%0d rdy=%0d cnt=%0d ovr=%0d sf=%0d st=%0d rd=%h(known=%0d)",
                 cyc, front_bank, frame_ready, frame_count, overrun, short_frame, fsm_state, rd_data,
                 e.fb, e.rdy, e.cnt, e.ovr, e.shrt, e.st, e.rd, e.rd_known);
      end
    end
  end

  logic [DW-1:0] rd8;
  bit            lk;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) begin
        m_known[b][i] = 0;
        m_bk[b][i]    = '0;
      end
    model_reset();

    // leading beats without sof are ignored, then one counting frame
    do_reset(3);
    for (int i = 0; i < 5; i++) step(1, DW'($urandom_range(0, 255)), 0, 0, '0, 0);
    for (int i = 0; i < N; i++) step(1, DW'(i), i == 0, 0, '0, 0);
    idle(AW'(7));
    idle('0);

    // three back-to-back frames, sof on the first beat only
    do_reset(2);
    for (int i = 0; i < 3 * N; i++) step(1, DW'($urandom_range(0, 255)), i == 0, 0, '0, 0);
    read_all();

    // reader lock across the frame end; beats dropped in HOLD; clear vs set
    do_reset(2);
    for (int i = 0; i < N; i++) step(1, DW'(i), i == 0, i == N - 1, '0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'hEE, 0, 1, '0, 0);
    step(1, 8'hEE, 0, 1, '0, 1);
    step(0, '0, 0, 1, '0, 1);
    step(1, 8'hEE, 0, 0, '0, 0);
    for (int i = 0; i < N; i++) step(1, DW'(8'h40 + i), 0, 0, AW'(i), 0);
    read_all();

    // short frame discarded by an early sof
    do_reset(2);
    for (int i = 0; i < 10; i++) step(1, DW'(8'h11 + i), i == 0, 0, '0, 0);
    for (int i = 0; i < N; i++) step(1, 8'hA5, i == 0, 0, '0, 0);
    read_all();

    // reset in the middle of a frame
    do_reset(2);
    for (int i = 0; i < 20; i++) step(1, DW'($urandom_range(0, 255)), i == 0, 0, '0, 0);
    do_reset(2);
    for (int i = 0; i < 3; i++) step(1, 8'h77, 0, 0, '0, 0);
    for (int i = 0; i < N; i++) step(1, DW'(8'hC0 + i), i == 0, 0, '0, 0);
    read_all();

    // frame_count wraps after 256 swaps
    do_reset(2);
    for (int i = 0; i < 257 * N; i++) step(1, DW'($urandom_range(0, 255)), i == 0, 0, '0, 0);
    idle('0);

    // random traffic
    do_reset(2);
    lk = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) lk = !lk;
      rd8 = DW'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, rd8, $urandom_range(0, 39) == 0, lk,
           AW'($urandom_range(0, N - 1)), $urandom_range(0, 29) == 0);
    end
    idle('0);

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
